answer_countdown: RTL and testbench

Round timer that sits directly downstream of the player-selection stage.
- Starts when Start is released.
- Counts down the grab window until a player is selected (Timer_Start), then counts down the answer window.
- Drives TimeOver_Block back into the selection stage and a timeout buzzer pulse.
- Outputs the remaining seconds as two BCD digits for the seven-segment display stage.

---
 rtl/answer_pkg.sv | 48 ++++
 rtl/sec_tick_gen.sv | 37 +++
 rtl/answer_countdown.sv | 154 +++++++++++++++
 tb/tb_answer_countdown.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/answer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : answer_pkg
//  Purpose  : Shared phase encoding and two-digit BCD helpers for the round
//             timer (answer_countdown and its prescaler).
//  Revision : 1.0 - initial release
// ============================================================================
package answer_pkg;

  // Phase encoding, also driven directly on the Phase output
  typedef logic [1:0] phase_t;
  localparam logic [1:0] c_PH_IDLE    = 2'd0;
  localparam logic [1:0] c_PH_GRAB    = 2'd1;
  localparam logic [1:0] c_PH_ANSWER  = 2'd2;
  localparam logic [1:0] c_PH_TIMEOUT = 2'd3;

  // Two BCD digits of remaining seconds
  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd2_t;

  localparam bcd2_t c_BCD_ZERO = '{tens: 4'd0, ones: 4'd0};
  localparam bcd2_t c_BCD_ONE  = '{tens: 4'd0, ones: 4'd1};

  // One-second decrement; 00 is left untouched
  function automatic bcd2_t bcd_dec(input bcd2_t v);
    bcd2_t r;
    r = v;
    if (v.ones != 4'd0) begin
      r.ones = v.ones - 4'd1;
    end else if (v.tens != 4'd0) begin
      r.ones = 4'd9;
      r.tens = v.tens - 4'd1;
    end
    return r;
  endfunction

  // Elaboration-time seconds to BCD conversion (0..99)
  function automatic bcd2_t sec_to_bcd(input int s);
    bcd2_t r;
    r.tens = 4'(s / 10);
    r.ones = 4'(s % 10);
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sec_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module   : sec_tick_gen
//  Purpose  : One-second prescaler. Emits a single-cycle tick every TICK_DIV
//             clocks; 'clear' restarts the count so the first tick after a
//             clear arrives TICK_DIV cycles later.
//  Revision : 1.0 - initial release
// ============================================================================
module sec_tick_gen #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic clear,
  output logic tick
);

  localparam int              c_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_W-1:0]  c_LAST = c_W'(TICK_DIV - 1);

  logic [c_W-1:0] r_cnt;

  // Free-running 0..TICK_DIV-1 counter, restarted by clear
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_cnt <= '0;
    end else if (clear || (r_cnt == c_LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/answer_countdown.sv
`default_nettype none
// ============================================================================
//  Module   : answer_countdown
//  Purpose  : Quiz round timer. Counts the grab window, switches to the answer
//             window once a player is selected, flags expiry back to the
//             selection stage and pulses the timeout buzzer.
//  Revision : 1.0 - initial release
// ============================================================================
module answer_countdown
  import answer_pkg::*;
#(
  parameter int TICK_DIV       = 50_000_000,
  parameter int GRAB_SECONDS   = 10,
  parameter int ANSWER_SECONDS = 30,
  parameter int BUZZ_CYCLES    = 25_000_000
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       Start,
  input  logic       Timer_Start,
  output logic       TimeOver_Block,
  output logic [3:0] Time_Tens,
  output logic [3:0] Time_Ones,
  output logic       Buzzer_Timeout,
  output logic [1:0] Phase
);

  localparam bcd2_t          c_GRAB_BCD   = sec_to_bcd(GRAB_SECONDS);
  localparam bcd2_t          c_ANSWER_BCD = sec_to_bcd(ANSWER_SECONDS);
  localparam int             c_BW         = (BUZZ_CYCLES > 1) ? $clog2(BUZZ_CYCLES + 1) : 1;
  localparam logic [c_BW-1:0] c_BUZZ_LAST = c_BW'(BUZZ_CYCLES - 1);

  phase_t          r_state;
  bcd2_t           r_bcd;
  logic            r_block;
  logic            r_buzz;
  logic [c_BW-1:0] r_buzz_cnt;

  phase_t w_state_nxt;
  bcd2_t  w_bcd_nxt;
  logic   w_block_nxt;
  logic   w_tick;
  logic   w_clear;
  logic   w_enter_timeout;

  // Prescaler restarts whenever a state is (re)entered, so every window
  // begins with a full second
  assign w_clear = Start || (w_state_nxt != r_state);

  sec_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .CLK   (CLK),
    .RSTn  (RSTn),
    .clear (w_clear),
    .tick  (w_tick)
  );

  // Next-state, display and block decision; Start overrides everything
  always_comb begin
    w_state_nxt = r_state;
    w_bcd_nxt   = r_bcd;
    w_block_nxt = r_block;
    if (Start) begin
      w_state_nxt = c_PH_IDLE;
      w_bcd_nxt   = c_BCD_ZERO;
      w_block_nxt = 1'b0;
    end else begin
      case (r_state)
        c_PH_IDLE: begin
          w_state_nxt = c_PH_GRAB;
          w_bcd_nxt   = c_GRAB_BCD;
          w_block_nxt = 1'b0;
        end
        c_PH_GRAB: begin
          // Selection wins over a coincident tick, even at the last second
          if (Timer_Start) begin
            w_state_nxt = c_PH_ANSWER;
            w_bcd_nxt   = c_ANSWER_BCD;
          end else if (w_tick) begin
            if (r_bcd == c_BCD_ONE) begin
              w_state_nxt = c_PH_TIMEOUT;
              w_bcd_nxt   = c_BCD_ZERO;
              w_block_nxt = 1'b1;
            end else begin
              w_bcd_nxt = bcd_dec(r_bcd);
            end
          end
        end
        c_PH_ANSWER: begin
          if (w_tick) begin
            if (r_bcd == c_BCD_ONE) begin
              w_state_nxt = c_PH_TIMEOUT;
              w_bcd_nxt   = c_BCD_ZERO;
              w_block_nxt = 1'b1;
            end else begin
              w_bcd_nxt = bcd_dec(r_bcd);
            end
          end
        end
        default: begin
          w_bcd_nxt   = c_BCD_ZERO;
          w_block_nxt = 1'b1;
        end
      endcase
    end
  end

  assign w_enter_timeout = (w_state_nxt == c_PH_TIMEOUT) && (r_state != c_PH_TIMEOUT);

  // Registered state, display and block flag
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state <= c_PH_IDLE;
      r_bcd   <= c_BCD_ZERO;
      r_block <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_bcd   <= w_bcd_nxt;
      r_block <= w_block_nxt;
    end
  end

  // Buzzer pulse: high from the TIMEOUT entry edge for BUZZ_CYCLES cycles
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_buzz     <= 1'b0;
      r_buzz_cnt <= '0;
    end else if (Start) begin
      r_buzz     <= 1'b0;
      r_buzz_cnt <= '0;
    end else if (w_enter_timeout) begin
      r_buzz     <= 1'b1;
      r_buzz_cnt <= c_BUZZ_LAST;
    end else if (r_state == c_PH_TIMEOUT) begin
      if (r_buzz_cnt != '0) begin
        r_buzz_cnt <= r_buzz_cnt - 1'b1;
      end else begin
        r_buzz <= 1'b0;
      end
    end else begin
      r_buzz     <= 1'b0;
      r_buzz_cnt <= '0;
    end
  end

  assign Phase          = r_state;
  assign Time_Tens      = r_bcd.tens;
  assign Time_Ones      = r_bcd.ones;
  assign TimeOver_Block = r_block;
  assign Buzzer_Timeout = r_buzz;

endmodule
`default_nettype wire

// File: tb/tb_answer_countdown.sv
`default_nettype none
// ============================================================================
//  Module   : tb_answer_countdown
//  Purpose  : Self-checking bench for answer_countdown: directed round
//             scenarios followed by randomized Start/Timer_Start/reset
//             activity, all compared against a seconds-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_answer_countdown;

  localparam int T = 4;   // TICK_DIV
  localparam int G = 3;   // GRAB_SECONDS
  localparam int A = 5;   // ANSWER_SECONDS
  localparam int B = 6;   // BUZZ_CYCLES

  logic       CLK = 1'b0;
  logic       RSTn;
  logic       Start;
  logic       Timer_Start;
  logic       TimeOver_Block;
  logic [3:0] Time_Tens;
  logic [3:0] Time_Ones;
  logic       Buzzer_Timeout;
  logic [1:0] Phase;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: phase number, remaining seconds, edges since entry
  int m_ph, m_sec, m_age, m_block;

  answer_countdown #(
    .TICK_DIV       (T),
    .GRAB_SECONDS   (G),
    .ANSWER_SECONDS (A),
    .BUZZ_CYCLES    (B)
  ) dut (
    .CLK            (CLK),
    .RSTn           (RSTn),
    .Start          (Start),
    .Timer_Start    (Timer_Start),
    .TimeOver_Block (TimeOver_Block),
    .Time_Tens      (Time_Tens),
    .Time_Ones      (Time_Ones),
    .Buzzer_Timeout (Buzzer_Timeout),
    .Phase          (Phase)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ph = 0; m_sec = 0; m_age = 0; m_block = 0;
  endtask

  // One clock edge of the timer rules, expressed on integer seconds
  task automatic model_edge();
    bit tick;
    if (Start) begin
      m_ph = 0; m_sec = 0; m_age = 0; m_block = 0;
    end else begin
      tick = ((m_age % T) == T - 1);
      case (m_ph)
        0: begin m_ph = 1; m_sec = G; m_age = 0; end
        1, 2: begin
          if (m_ph == 1 && Timer_Start) begin
            m_ph = 2; m_sec = A; m_age = 0;
          end else if (tick && m_sec == 1) begin
            m_ph = 3; m_sec = 0; m_block = 1; m_age = 0;
          end else begin
            if (tick) m_sec = m_sec - 1;
            m_age++;
          end
        end
        default: m_age++;
      endcase
    end
  endtask

  task automatic check_all();
    chk("phase", Phase,          4'(m_ph));
    chk("tens",  Time_Tens,      4'(m_sec / 10));
    chk("ones",  Time_Ones,      4'(m_sec % 10));
    chk("block", {3'b0, TimeOver_Block}, 4'(m_block));
    chk("buzz",  {3'b0, Buzzer_Timeout}, 4'((m_ph == 3 && m_age < B) ? 1 : 0));
  endtask

  task automatic cyc();
    @(posedge CLK);
    model_edge();
    #1;
    check_all();
  endtask

  // Reset pulse placed between edges; outputs must clear before the next edge
  task automatic async_pulse();
    #2 RSTn = 1'b0;
    #1 model_reset();
    check_all();
    #1 RSTn = 1'b1;
  endtask

  initial begin
    RSTn = 1'b0; Start = 1'b1; Timer_Start = 1'b0;
    model_reset();
    #13;
    check_all();
    @(negedge CLK) RSTn = 1'b1;
    repeat (3) cyc();

    // Grab window expiry and buzzer pulse
    Start = 1'b0;
    cyc();
    chk("grab_entry_ones", Time_Ones, 4'd3);
    repeat (12) cyc();
    chk("grab_timeout_phase", Phase, 4'd3);
    repeat (10) cyc();

    // Answer path
    Start = 1'b1; cyc();
    Start = 1'b0; repeat (5) cyc();
    Timer_Start = 1'b1;
    repeat (30) cyc();

    // Selection coinciding with the final grab tick
    Start = 1'b1; Timer_Start = 1'b0; cyc();
    Start = 1'b0; cyc();
    repeat (11) cyc();
    Timer_Start = 1'b1; cyc();
    chk("coinc_phase", Phase, 4'd2);
    chk("coinc_ones", Time_Ones, 4'd5);
    chk("coinc_block", {3'b0, TimeOver_Block}, 4'd0);
    repeat (3) cyc();

    // Start mid-answer, then Start during the buzzer pulse
    Start = 1'b1; Timer_Start = 1'b0; cyc();
    Start = 1'b0; cyc();
    Timer_Start = 1'b1; cyc();
    repeat (8) cyc();
    Start = 1'b1; cyc();
    chk("start_mid_phase", Phase, 4'd0);
    Start = 1'b0; Timer_Start = 1'b0; cyc();
    repeat (13) cyc();
    Start = 1'b1; cyc();
    chk("buzz_kill", {3'b0, Buzzer_Timeout}, 4'd0);

    // Asynchronous reset in the middle of the grab count
    Start = 1'b0; cyc();
    repeat (5) cyc();
    async_pulse();
    cyc();
    chk("restart_ones", Time_Ones, 4'd3);
    repeat (4) cyc();

    // Randomized activity
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 24) == 0) begin
        Start = 1'b1;
        Timer_Start = 1'b0;
      end else begin
        Start = 1'b0;
        if ($urandom_range(0, 11) == 0) Timer_Start = 1'b1;
        else if ($urandom_range(0, 39) == 0) Timer_Start = 1'b0;
      end
      if ($urandom_range(0, 199) == 0) async_pulse();
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
